// File: rtl/jzjpcc_mmio_ports.sv
// Memory-mapped 32-bit I/O ports: output/direction registers, synchronized
// inputs and per-bit change flags with a registered interrupt.
module jzjpcc_mmio_ports #(
    parameter int          NUM_PORTS   = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] DATA_BASE   = 32'hFFFFFFE0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:2]            address,
    input  logic                   writeEnable,
    input  logic                   readEnable,
    input  logic [3:0]             byteEnable,
    input  logic [31:0]            writeData,
    output logic [31:0]            readData,
    output logic                   readValid,
    output logic                   hit,
    input  logic [NUM_PORTS*32-1:0] mmioInputs,
    output logic [NUM_PORTS*32-1:0] mmioOutputs,
    output logic [NUM_PORTS*32-1:0] mmioDirections,
    output logic                   changeIrq
);

    localparam int          W       = NUM_PORTS * 32;
    localparam int          ARM_MAX = SYNC_STAGES + 1;
    localparam logic [29:0] DATA_W  = DATA_BASE[31:2];
    localparam logic [29:0] DIR_W   = DATA_W - 30'(NUM_PORTS);
    localparam logic [29:0] FLG_W   = DATA_W - 30'(2 * NUM_PORTS);

    logic [W-1:0]  sin;
    logic [W-1:0]  outputs_q, outputs_d;
    logic [W-1:0]  directions_q, directions_d;
    logic [W-1:0]  flags_q, flags_d;
    logic [W-1:0]  prev_q, prev_d;
    logic [2:0]    arm_q, arm_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          read_valid_q, read_valid_d;
    logic          irq_q, irq_d;
    logic [W-1:0]  w1c;
    logic [31:0]   bmask;
    logic          armed;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign sin = mmioInputs;
        end else begin : g_sync
            logic [W-1:0] sync_q [SYNC_STAGES];
            logic [W-1:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = mmioInputs;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_d[k] = sync_q[k-1];
                end
            end

            always_ff @(posedge clock) begin
                for (int k = 0; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= reset ? sync_d[k] : '0;
                end
            end

            assign sin = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign bmask = {{8{byteEnable[3]}}, {8{byteEnable[2]}},
                    {8{byteEnable[1]}}, {8{byteEnable[0]}}};
    assign armed = (arm_q == 3'(ARM_MAX));

    always_comb begin
        outputs_d    = outputs_q;
        directions_d = directions_q;
        w1c          = '0;
        read_data_d  = '0;
        hit          = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (address == DATA_W + 30'(i)) begin
                hit = 1'b1;
                if (readEnable) read_data_d = sin[i*32 +: 32];
                if (writeEnable) begin
                    outputs_d[i*32 +: 32] = (outputs_q[i*32 +: 32] & ~bmask)
                                          | (writeData & bmask);
                end
            end
            if (address == DIR_W + 30'(i)) begin
                hit = 1'b1;
                if (readEnable) read_data_d = directions_q[i*32 +: 32];
                if (writeEnable) begin
                    directions_d[i*32 +: 32] = (directions_q[i*32 +: 32] & ~bmask)
                                             | (writeData & bmask);
                end
            end
            if (address == FLG_W + 30'(i)) begin
                hit = 1'b1;
                if (readEnable) read_data_d = flags_q[i*32 +: 32];
                if (writeEnable) w1c[i*32 +: 32] = writeData & bmask;
            end
        end
        read_valid_d = readEnable && hit;
        prev_d       = sin;
        arm_d        = armed ? arm_q : arm_q + 3'd1;
        // A newly detected edge beats a coincident clear.
        flags_d      = (flags_q & ~w1c) | (armed ? (sin ^ prev_q) : '0);
        irq_d        = |flags_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            outputs_q    <= '0;
            directions_q <= '0;
            flags_q      <= '0;
            prev_q       <= '0;
            arm_q        <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            outputs_q    <= outputs_d;
            directions_q <= directions_d;
            flags_q      <= flags_d;
            prev_q       <= prev_d;
            arm_q        <= arm_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            irq_q        <= irq_d;
        end
    end

    assign readData       = read_data_q;
    assign readValid      = read_valid_q;
    assign mmioOutputs    = outputs_q;
    assign mmioDirections = directions_q;
    assign changeIrq      = irq_q;

endmodule

// File: tb/tb_jzjpcc_mmio_ports.sv
// Scoreboard bench for jzjpcc_mmio_ports: reads push expected data,
// a monitor pops and compares whenever readValid is seen.
module tb_jzjpcc_mmio_ports;

    localparam int NP = 8;
    localparam int W  = NP * 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:2]   address;
    logic          writeEnable;
    logic          readEnable;
    logic [3:0]    byteEnable;
    logic [31:0]   writeData;
    logic [31:0]   readData;
    logic          readValid;
    logic          hit;
    logic [W-1:0]  mmioInputs;
    logic [W-1:0]  mmioOutputs;
    logic [W-1:0]  mmioDirections;
    logic          changeIrq;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];
    logic [W-1:0] exp_v;

    jzjpcc_mmio_ports #(
        .NUM_PORTS(NP), .SYNC_STAGES(2), .DATA_BASE(32'hFFFFFFE0)
    ) dut (
        .clock(clock), .reset(reset), .address(address),
        .writeEnable(writeEnable), .readEnable(readEnable),
        .byteEnable(byteEnable), .writeData(writeData),
        .readData(readData), .readValid(readValid), .hit(hit),
        .mmioInputs(mmioInputs), .mmioOutputs(mmioOutputs),
        .mmioDirections(mmioDirections), .changeIrq(changeIrq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (readValid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: got %h expected none", readData);
            end else begin
                chk("read_data", W'(readData), W'(exp_q.pop_front()));
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d);
        @(negedge clock);
        address = a[31:2]; byteEnable = be; writeData = d; writeEnable = 1'b1;
        @(negedge clock);
        writeEnable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        @(negedge clock);
        address = a[31:2]; readEnable = 1'b1;
        exp_q.push_back(e);
        @(negedge clock);
        readEnable = 1'b0;
    endtask

    task automatic hit_at(input logic [31:0] a, input logic e);
        @(negedge clock);
        address = a[31:2];
        #1;
        chk("hit", W'(hit), W'(e));
    endtask

    initial begin
        reset = 1'b0; address = '0; writeEnable = 1'b0; readEnable = 1'b0;
        byteEnable = '0; writeData = '0; mmioInputs = '0;
        mmioInputs[2*32 +: 32] = 32'hFFFFFFFF;
        repeat (3) @(negedge clock);
        chk("rst_valid", W'(readValid), '0);
        chk("rst_data", W'(readData), '0);
        chk("rst_out", mmioOutputs, '0);
        chk("rst_dir", mmioDirections, '0);
        chk("rst_irq", W'(changeIrq), '0);
        reset = 1'b1;

        // Input held high through reset release must not raise flags.
        repeat (10) @(negedge clock);
        chk("arm_irq", W'(changeIrq), '0);
        rd(32'hFFFFFFA8, 32'h0);

        hit_at(32'hFFFFFFFC, 1'b1);
        hit_at(32'hFFFFFFA0, 1'b1);
        hit_at(32'hFFFFFFDC, 1'b1);
        hit_at(32'hFFFFFF9C, 1'b0);

        wr(32'hFFFFFFE4, 4'b0101, 32'hAABBCCDD);
        exp_v = '0; exp_v[63:32] = 32'h00BB00DD;
        chk("byte_wr", mmioOutputs, exp_v);
        wr(32'hFFFFFFE4, 4'b1010, 32'h11223344);
        exp_v[63:32] = 32'h11BB33DD;
        chk("byte_wr2", mmioOutputs, exp_v);
        wr(32'hFFFFFFE4, 4'b0000, 32'h99999999);
        chk("be_zero", mmioOutputs, exp_v);
        wr(32'hFFFFFF9C, 4'b1111, 32'h99999999);
        chk("miss_out", mmioOutputs, exp_v);
        chk("miss_dir", mmioDirections, '0);

        wr(32'hFFFFFFC8, 4'b1111, 32'hCAFEF00D);
        exp_v = '0; exp_v[95:64] = 32'hCAFEF00D;
        chk("dir_wr", mmioDirections, exp_v);
        rd(32'hFFFFFFC8, 32'hCAFEF00D);
        rd(32'hFFFFFFC0, 32'h0);
        rd(32'hFFFFFFE4, 32'h0);

        @(negedge clock);
        address = 30'h3FFFFFE7; readEnable = 1'b1;
        @(negedge clock);
        readEnable = 1'b0;
        chk("miss_valid", W'(readValid), '0);

        mmioInputs[3*32 +: 32] = 32'h12345678;
        repeat (3) @(negedge clock);
        rd(32'hFFFFFFEC, 32'h12345678);
        rd(32'hFFFFFFAC, 32'h12345678);
        chk("irq_p3", W'(changeIrq), 1);
        wr(32'hFFFFFFAC, 4'b1111, 32'hFFFFFFFF);
        @(negedge clock);
        chk("irq_clr_p3", W'(changeIrq), '0);

        // Edge timing: flag lands on the third edge, irq on the fourth.
        @(negedge clock);
        mmioInputs[5] = 1'b1;
        repeat (3) @(negedge clock);
        chk("irq_early", W'(changeIrq), '0);
        @(negedge clock);
        chk("irq_set", W'(changeIrq), 1);
        rd(32'hFFFFFFA0, 32'h20);
        wr(32'hFFFFFFA0, 4'b1111, 32'h20);
        @(negedge clock);
        chk("irq_clr", W'(changeIrq), '0);
        rd(32'hFFFFFFA0, 32'h0);

        mmioInputs[5] = 1'b0;
        repeat (4) @(negedge clock);
        wr(32'hFFFFFFA0, 4'b1110, 32'h20);
        rd(32'hFFFFFFA0, 32'h20);
        wr(32'hFFFFFFA0, 4'b0001, 32'h20);
        rd(32'hFFFFFFA0, 32'h0);

        // Clear coincides with a new detection on the same bit.
        @(negedge clock);
        mmioInputs[5] = 1'b1;
        repeat (2) @(negedge clock);
        address = 30'h3FFFFFE8; byteEnable = 4'b1111;
        writeData = 32'h20; writeEnable = 1'b1;
        @(negedge clock);
        writeEnable = 1'b0;
        rd(32'hFFFFFFA0, 32'h20);
        wr(32'hFFFFFFA0, 4'b1111, 32'h20);

        @(negedge clock);
        address = 30'h3FFFFFF4; byteEnable = 4'b1111;
        writeData = 32'hFFFF0000; writeEnable = 1'b1; readEnable = 1'b1;
        exp_q.push_back(32'h0);
        @(negedge clock);
        writeEnable = 1'b0; readEnable = 1'b0;
        rd(32'hFFFFFFD0, 32'hFFFF0000);

        mmioInputs[3*32 +: 32] = 32'h0;
        repeat (5) @(negedge clock);
        chk("irq_pre_rst", W'(changeIrq), 1);

        // Reset lands on the same edge as a read and a write.
        address = 30'h3FFFFFFB; readEnable = 1'b1; writeEnable = 1'b1;
        byteEnable = 4'b1111; writeData = 32'h55; reset = 1'b0;
        @(negedge clock);
        readEnable = 1'b0; writeEnable = 1'b0;
        chk("mid_valid", W'(readValid), '0);
        chk("mid_data", W'(readData), '0);
        chk("mid_out", mmioOutputs, '0);
        chk("mid_dir", mmioDirections, '0);
        chk("mid_irq", W'(changeIrq), '0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_reads: got %0d left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jzjpcc_mmio_ports.md
JZJPCC_MMIO_PORTS -- requirements
Module: jzjpcc_mmio_ports

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 8, meaning the number of 32-bit I/O ports (legal 1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the number of input synchronizer flops per bit (legal 0..3; 0 = direct).
REQ-003 SHALL have parameter DATA_BASE, default 32'hFFFFFFE0, meaning the byte address of port 0 data (word aligned); region SHALL NOT wrap past 32'hFFFFFFFF or below 0.
REQ-004 SHALL have ports: clock  in  1  sole clock, rising edge; reset  in  1  synchronous, active-low (0 = reset at next rising edge).
REQ-005 SHALL have ports: address  in  [31:2]  word address; writeEnable  in  1  write strobe; readEnable  in  1  read strobe; byteEnable  in  4  per-byte write mask; writeData  in  32  store data.
REQ-006 SHALL have ports: readData  out  32  registered load data; readValid  out  1  readData valid; hit  out  1  combinational, address is inside this block's map.
REQ-007 SHALL have ports: mmioInputs  in  32 x NUM_PORTS  raw port inputs; mmioOutputs  out  32 x NUM_PORTS  output registers; mmioDirections  out  32 x NUM_PORTS  per-bit direction (1 = drive); changeIrq  out  1  registered change interrupt.

Function
REQ-008 Address map (words) SHALL be: data i at DATA_BASE+4i; direction i at DATA_BASE-4*NUM_PORTS+4i; change flags i at DATA_BASE-8*NUM_PORTS+4i; hit=1 only for these 3*NUM_PORTS words.
REQ-009 Data-word write SHALL update mmioOutputs[i] bytes where byteEnable=1, other bytes unchanged, visible the cycle after the write edge.
REQ-010 Direction-word write SHALL update mmioDirections[i] with the same byte-masked rule.
REQ-011 Flag-word write SHALL be write-1-to-clear per bit, gated by byteEnable.
REQ-012 Writes with hit=0 or byteEnable=4'b0000 SHALL have no effect.
REQ-013 Reads SHALL have 1-cycle latency: readEnable&hit at edge N -> readValid=1 and readData valid after edge N; else readValid=0 and readData=0.
REQ-014 Data-word read SHALL return the synchronized input sin[i], not mmioOutputs; direction and flag reads SHALL return register contents.
REQ-015 sin[i] SHALL equal mmioInputs[i] delayed SYNC_STAGES cycles (SYNC_STAGES=0: combinational).
REQ-016 Block SHALL keep prev[i] = sin[i] of previous cycle; each cycle flag bits SHALL set where sin[i]^prev[i]=1, once armed.
REQ-017 Arming: a counter SHALL count SYNC_STAGES+1 cycles after reset release; flags SHALL not set before it saturates; counter SHALL then hold.
REQ-018 Simultaneous set and W1C on the same bit SHALL leave the bit set.
REQ-019 Simultaneous read and write of the same word SHALL return the pre-write value.
REQ-020 changeIrq SHALL be registered OR of all flag bits, i.e. asserts one cycle after any flag becomes 1, deasserts one cycle after all clear.
REQ-021 readEnable and writeEnable both high SHALL perform both operations independently.

Reset
REQ-022 With reset=0 at a rising edge, mmioOutputs, mmioDirections, flags, sync flops, prev, arming counter, readData, readValid, changeIrq SHALL all become 0.
REQ-023 Reset asserted mid-operation SHALL abort any pending read (readValid=0 next cycle) and discard a coincident write.
REQ-024 Reset SHALL have no effect between clock edges.

Verification
REQ-025 Byte write: NUM_PORTS=8, write 32'hAABBCCDD to 32'hFFFFFFE4 byteEnable=4'b0101 after reset -> mmioOutputs[1]=32'h00BB00DD; other ports 0.
REQ-026 Readback: SYNC_STAGES=2, mmioInputs[3]=32'h12345678 held, read 32'hFFFFFFEC -> readValid=1, readData=32'h12345678 one cycle later; read 32'hFFFFFFC0 -> direction 0 returned.
REQ-027 Change flag: toggle mmioInputs[0] bit 5 after arming -> flag word 32'hFFFFFFA0 bit 5 set SYNC_STAGES+1 cycles later, changeIrq=1 next cycle; write 32'h20 there -> flag and changeIrq clear.
REQ-028 Set-wins: W1C bit 5 in same cycle a new bit-5 toggle is detected -> bit 5 remains 1.
REQ-029 Arming: mmioInputs[2]=32'hFFFFFFFF through reset release -> no flags set, changeIrq stays 0.
REQ-030 Mid-read reset: readEnable to valid address with reset=0 same edge -> readValid=0, readData=0, all outputs 0.
